// File: rtl/vector_lane_sequencer.sv
// vector_lane_sequencer
// Sequences one V-element vector operation across LANES lane ALUs in
// BEATS = V/LANES beats, then reassembles the in-order lane results into a
// full result vector and reports completion with a start/ready/done handshake.
//
// Ports:
//   CLK, RST             clock (rising edge), asynchronous active-low reset
//   start_i, op_type_i   op request and type; taken only while ready_o=1
//   stall_i              suppresses beat issue in the current cycle
//   ready_o, busy_o      idle / operation in progress (busy_o = !ready_o)
//   beat_o, op_type_o    beat index and latched op type to the fork stage
//   issue_o              lane operands valid this cycle
//   res_valid_i          lane results valid (strictly in issue order)
//   res_lanes_i          lane results, lane l in bits [l*N +: N]
//   res_vec_o            assembled vector, element e in bits [e*N +: N]
//   done_o               one-cycle completion pulse
//   err_o                sticky protocol error (only with SEQ_PROTOCOL_CHECK_EN)
//
// Optional build macro SEQ_PROTOCOL_CHECK_EN adds err_o and its checker.
//
// state | meaning
// IDLE  | ready for start_i
// ISSUE | issuing one beat per unstalled cycle, results may already return
// DRAIN | all beats issued, waiting for the remaining results
// DONE  | all results captured, done_o high for this one cycle
module vector_lane_sequencer #(
    parameter int N     = 32,
    parameter int V     = 20,
    parameter int LANES = 4,
    localparam int BEATS = V / LANES,
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start_i,
    input  logic [1:0]         op_type_i,
    input  logic               stall_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic [BW-1:0]      beat_o,
    output logic [1:0]         op_type_o,
    output logic               issue_o,
    input  logic               res_valid_i,
    input  logic [LANES*N-1:0] res_lanes_i,
    output logic [V*N-1:0]     res_vec_o,
    output logic               done_o
`ifdef SEQ_PROTOCOL_CHECK_EN
    ,
    output logic               err_o
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

    logic [1:0]     r_state;
    logic [BW-1:0]  r_beat;
    logic [BW-1:0]  r_ret_cnt;
    logic [1:0]     r_op_type;
    logic [V*N-1:0] r_res_vec;

    logic w_issue;
    logic w_capture;

    assign w_issue   = (r_state == ISSUE) && !stall_i;
    assign w_capture = res_valid_i && ((r_state == ISSUE) || (r_state == DRAIN));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_beat    <= '0;
            r_ret_cnt <= '0;
            r_op_type <= '0;
            r_res_vec <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state   <= ISSUE;
                        r_beat    <= '0;
                        r_ret_cnt <= '0;
                        r_op_type <= op_type_i;
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        // The last beat index is left on beat_o through DRAIN.
                        if (r_beat == BEAT_LAST) begin
                            r_state <= DRAIN;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Result capture overrides the issue transition: the final result
            // ends the op regardless of where issue stands.
            if (w_capture) begin
                for (int l = 0; l < LANES; l++) begin
                    r_res_vec[(l * BEATS + int'(r_ret_cnt)) * N +: N] <= res_lanes_i[l * N +: N];
                end
                r_ret_cnt <= r_ret_cnt + 1'b1;
                if (r_ret_cnt == BEAT_LAST) begin
                    r_state <= DONE;
                end
            end
        end
    end

    assign ready_o   = (r_state == IDLE);
    assign busy_o    = !ready_o;
    assign beat_o    = r_beat;
    assign op_type_o = r_op_type;
    assign issue_o   = w_issue;
    assign res_vec_o = r_res_vec;
    assign done_o    = (r_state == DONE);

`ifdef SEQ_PROTOCOL_CHECK_EN
    logic          r_err;
    logic [BW:0]   w_issued;
    logic          w_proto_err;

    // Beats issued before this cycle: r_beat counts them during ISSUE; in
    // DRAIN every beat is out. A result in the same cycle as its issue is
    // impossible, so the current cycle's issue does not count.
    assign w_issued    = (r_state == DRAIN) ? (BW + 1)'(BEATS) : {1'b0, r_beat};
    assign w_proto_err = (res_valid_i && ((r_state == IDLE) || (r_state == DONE)))
                       || (w_capture && ({1'b0, r_ret_cnt} >= w_issued))
                       || (start_i && busy_o);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_err <= 1'b0;
        end else if (w_proto_err) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

endmodule

// File: tb/tb_vector_lane_sequencer.sv
module tb_vector_lane_sequencer;

    localparam int N     = 32;
    localparam int V     = 20;
    localparam int LANES = 4;
    localparam int BEATS = 5;
    localparam int BW    = 3;

    logic               CLK;
    logic               RST;
    logic               start_i;
    logic [1:0]         op_type_i;
    logic               stall_i;
    logic               ready_o;
    logic               busy_o;
    logic [BW-1:0]      beat_o;
    logic [1:0]         op_type_o;
    logic               issue_o;
    logic               res_valid_i;
    logic [LANES*N-1:0] res_lanes_i;
    logic [V*N-1:0]     res_vec_o;
    logic               done_o;
`ifdef SEQ_PROTOCOL_CHECK_EN
    logic               err_o;
`endif

    vector_lane_sequencer #(.N(N), .V(V), .LANES(LANES)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start_i     (start_i),
        .op_type_i   (op_type_i),
        .stall_i     (stall_i),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .beat_o      (beat_o),
        .op_type_o   (op_type_o),
        .issue_o     (issue_o),
        .res_valid_i (res_valid_i),
        .res_lanes_i (res_lanes_i),
        .res_vec_o   (res_vec_o),
        .done_o      (done_o)
`ifdef SEQ_PROTOCOL_CHECK_EN
        ,
        .err_o       (err_o)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int         beat;
        logic [1:0] op;
    } issue_t;

    typedef struct {
        int beat;
        int base;
        bit dead;
    } resp_t;

    issue_t         exp_issue_q[$];
    logic [V*N-1:0] exp_done_q[$];
    resp_t          resp_q[$];

    int total = 0;
    int bad   = 0;
    int issue_cnt = 0;
    int cur_base  = 0;
    bit auto_resp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_vec(input string name, input logic [V*N-1:0] act, input logic [V*N-1:0] req);
        int first;
        first = -1;
        for (int e = 0; e < V; e++) begin
            if (first < 0 && act[e*N +: N] !== req[e*N +: N]) first = e;
        end
        total++;
        if (first >= 0) begin
            bad++;
            $display("FAIL %s element=%0d actual=%0h required=%0h", name, first,
                     act[first*N +: N], req[first*N +: N]);
        end
    endtask

    function automatic logic [V*N-1:0] mk_vec(input int base);
        logic [V*N-1:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++)
            for (int b = 0; b < BEATS; b++)
                v[(l*BEATS + b)*N +: N] = 32'(base + 100*l + b);
        return v;
    endfunction

    task automatic push_op(input logic [1:0] op, input int base);
        issue_t e;
        for (int b = 0; b < BEATS; b++) begin
            e.beat = b;
            e.op   = op;
            exp_issue_q.push_back(e);
        end
        exp_done_q.push_back(mk_vec(base));
    endtask

    // Lane model: replays queued results one per cycle, just after the edge.
    always @(posedge CLK) begin
        resp_t r;
        #1;
        if (resp_q.size() > 0) begin
            r = resp_q.pop_front();
            res_valid_i = 1'b1;
            for (int l = 0; l < LANES; l++)
                res_lanes_i[l*N +: N] = r.dead ? 32'hDEAD : 32'(r.base + 100*l + r.beat);
        end else begin
            res_valid_i = 1'b0;
            res_lanes_i = '0;
        end
    end

    // Monitor: pops expected issues and results whenever the DUT presents them.
    always @(negedge CLK) begin
        issue_t e;
        resp_t  r;
        logic [V*N-1:0] v;
        if (RST) begin
            if (issue_o) begin
                issue_cnt++;
                if (auto_resp) begin
                    r.beat = int'(beat_o);
                    r.base = cur_base;
                    r.dead = 1'b0;
                    resp_q.push_back(r);
                end
                if (exp_issue_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue actual=beat %0d required=no issue", beat_o);
                end else begin
                    e = exp_issue_q.pop_front();
                    chk("issue_beat", 64'(beat_o), 64'(e.beat));
                    chk("issue_op", 64'(op_type_o), 64'(e.op));
                end
            end
            if (done_o) begin
                if (exp_done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    v = exp_done_q.pop_front();
                    chk_vec("result_vec", res_vec_o, v);
                end
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input int base,
                          input int stall_mask, input int mid_start, input int exp_lat);
        int cnt;
        bit seen;
        push_op(op, base);
        cur_base  = base;
        auto_resp = 1'b1;
        issue_cnt = 0;
        @(posedge CLK); #1;
        start_i   = 1'b1;
        op_type_i = op;
        @(posedge CLK); #1;
        start_i   = 1'b0;
        op_type_i = ~op;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            cnt++;
            stall_i = (cnt < 32) ? stall_mask[cnt] : 1'b0;
            start_i = (cnt == mid_start);
            @(negedge CLK);
            if (cnt < 32 && stall_mask[cnt]) begin
                chk({name, "_stall_issue"}, 64'(issue_o), 64'd0);
                chk({name, "_stall_beat"}, 64'(beat_o), 64'd1);
            end
            if (done_o) seen = 1'b1;
            else begin
                @(posedge CLK); #1;
            end
        end
        stall_i = 1'b0;
        start_i = 1'b0;
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        chk({name, "_latency"}, 64'(cnt), 64'(exp_lat));
        chk({name, "_issue_pulses"}, 64'(issue_cnt), 64'd5);
        chk({name, "_op_type"}, 64'(op_type_o), 64'(op));
        chk({name, "_busy_in_done"}, 64'({ready_o, busy_o}), 64'b01);
        @(negedge CLK);
        chk({name, "_done_single"}, 64'(done_o), 64'd0);
        chk({name, "_ready_after"}, 64'(ready_o), 64'd1);
    endtask

    initial begin
        int cnt;
        bit seen;
        resp_t r;

        RST = 1'b1;
        start_i = 1'b0;
        op_type_i = 2'b00;
        stall_i = 1'b0;
        res_valid_i = 1'b0;
        res_lanes_i = '0;
        #3 RST = 1'b0;
        #14;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_beat", 64'(beat_o), 64'd0);
        chk("rst_op", 64'(op_type_o), 64'd0);
        chk("rst_issue_done", 64'({issue_o, done_o}), 64'd0);
        chk("rst_vec_zero", 64'(res_vec_o == '0), 64'd1);
        @(negedge CLK);
        RST = 1'b1;

        // Basic op
        run_op("basic", 2'b01, 0, 0, -1, 7);
        chk("basic_elem7", 64'(res_vec_o[7*N +: N]), 64'd102);
        chk("basic_elem19", 64'(res_vec_o[19*N +: N]), 64'd304);
`ifdef SEQ_PROTOCOL_CHECK_EN
        chk("basic_err", 64'(err_o), 64'd0);
`endif

        // Stall on the 2nd and 3rd ISSUE cycles
        run_op("stall", 2'b10, 1000, 32'b1100, -1, 9);

        // Delayed results: nothing during ISSUE, then five back-to-back in DRAIN
        push_op(2'b11, 2000);
        auto_resp = 1'b0;
        issue_cnt = 0;
        @(posedge CLK); #1;
        start_i = 1'b1;
        op_type_i = 2'b11;
        @(posedge CLK); #1;
        start_i = 1'b0;
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            cnt++;
            @(negedge CLK);
            if (cnt == 8) begin
                chk("delay_drain_issue", 64'(issue_o), 64'd0);
                chk("delay_drain_done", 64'(done_o), 64'd0);
                chk("delay_drain_busy", 64'(busy_o), 64'd1);
                chk("delay_drain_beat", 64'(beat_o), 64'd4);
                for (int b = 0; b < BEATS; b++) begin
                    r.beat = b;
                    r.base = 2000;
                    r.dead = 1'b0;
                    resp_q.push_back(r);
                end
            end
            if (done_o) seen = 1'b1;
            else begin
                @(posedge CLK); #1;
            end
        end
        chk("delay_done_seen", 64'(seen), 64'd1);
        chk("delay_latency", 64'(cnt), 64'd14);
        chk("delay_issue_pulses", 64'(issue_cnt), 64'd5);
        @(negedge CLK);
`ifdef SEQ_PROTOCOL_CHECK_EN
        chk("delay_err", 64'(err_o), 64'd0);
`endif

        // Ignored events: start mid-ISSUE, then a stray result in IDLE
        run_op("midstart", 2'b01, 3000, 0, 3, 7);
        auto_resp = 1'b0;
        r.beat = 0;
        r.base = 0;
        r.dead = 1'b1;
        resp_q.push_back(r);
        repeat (3) @(negedge CLK);
        chk_vec("idle_result_ignored", res_vec_o, mk_vec(3000));
        chk("idle_result_ready", 64'(ready_o), 64'd1);
`ifdef SEQ_PROTOCOL_CHECK_EN
        chk("ignored_err", 64'(err_o), 64'd1);
`endif

        // Reset after 3 issued beats and 2 captured results
        push_op(2'b10, 4000);
        cur_base = 4000;
        auto_resp = 1'b1;
        @(posedge CLK); #1;
        start_i = 1'b1;
        op_type_i = 2'b10;
        @(posedge CLK); #1;
        start_i = 1'b0;
        repeat (3) @(negedge CLK);
        @(posedge CLK); #2;
        RST = 1'b0;
        exp_issue_q.delete();
        exp_done_q.delete();
        resp_q.delete();
        #1;
        chk("midrst_ready", 64'(ready_o), 64'd1);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_issue", 64'(issue_o), 64'd0);
        chk("midrst_beat", 64'(beat_o), 64'd0);
        chk("midrst_vec_zero", 64'(res_vec_o == '0), 64'd1);
`ifdef SEQ_PROTOCOL_CHECK_EN
        chk("midrst_err", 64'(err_o), 64'd0);
`endif
        @(negedge CLK);
        RST = 1'b1;
        run_op("after_rst", 2'b01, 5000, 0, -1, 7);

        // Back-to-back with start_i held high
        push_op(2'b10, 6000);
        push_op(2'b01, 7000);
        cur_base = 6000;
        auto_resp = 1'b1;
        issue_cnt = 0;
        @(posedge CLK); #1;
        start_i = 1'b1;
        op_type_i = 2'b10;
        @(posedge CLK); #1;
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            cnt++;
            @(negedge CLK);
            if (done_o) seen = 1'b1;
        end
        chk("b2b_first_done", 64'(seen), 64'd1);
        chk("b2b_first_latency", 64'(cnt), 64'd7);
        cur_base = 7000;
        op_type_i = 2'b01;
        @(negedge CLK);
        chk("b2b_idle_after_done", 64'(ready_o), 64'd1);
        @(negedge CLK);
        chk("b2b_second_issue", 64'({issue_o, beat_o, op_type_o}), 64'({1'b1, 3'd0, 2'b01}));
        @(posedge CLK); #1;
        start_i = 1'b0;
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            cnt++;
            @(negedge CLK);
            if (done_o) seen = 1'b1;
        end
        chk("b2b_second_done", 64'(seen), 64'd1);
        chk("b2b_issue_pulses", 64'(issue_cnt), 64'd10);
        @(negedge CLK);
        chk("b2b_elem7", 64'(res_vec_o[7*N +: N]), 64'd7102);
`ifdef SEQ_PROTOCOL_CHECK_EN
        chk("b2b_err", 64'(err_o), 64'd1);
`endif

        repeat (2) @(negedge CLK);
        chk("issue_queue_empty", 64'(exp_issue_q.size()), 64'd0);
        chk("done_queue_empty", 64'(exp_done_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
